// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a variable-latency
// instruction memory and drives the IF/ID pipeline register, honouring
// decode-stage stalls (Freeze) and branch redirects (Branch_Taken).
//
// Memory handshake: Imem_Req/Imem_Addr form a request that completes on the
// first rising edge where Imem_Req and Imem_Ready are both high; Imem_Data is
// valid only in that cycle. Address is held stable while waiting, at most one
// request is outstanding, and Ready may already be high in the first Req cycle.
module if_stage #(
  parameter int unsigned           ADDR_W   = 32,
  parameter int unsigned           INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter int unsigned           PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Freeze,
  input  logic               Branch_Taken,
  input  logic [ADDR_W-1:0]  Branch_Addr,
  output logic               Imem_Req,
  output logic [ADDR_W-1:0]  Imem_Addr,
  input  logic               Imem_Ready,
  input  logic [INSTR_W-1:0] Imem_Data,
  output logic [ADDR_W-1:0]  IF_ID_PC,
  output logic [INSTR_W-1:0] IF_ID_Instr,
  output logic               IF_ID_Valid,
  output logic [1:0]         dbg_state_o
);

  // FETCH: request in flight / issuing. BUFFERED: a word arrived during a
  // stall and is parked. KILL: a redirect arrived while a request was pending;
  // the stale response must drain before the target can be fetched.
  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_BUFFERED = 2'd1,
    S_KILL     = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    target_q, target_d;
  logic [ADDR_W-1:0]    buf_pc_q, buf_pc_d;
  logic [INSTR_W-1:0]   buf_instr_q, buf_instr_d;
  logic [ADDR_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic [INSTR_W-1:0]   ifid_instr_q, ifid_instr_d;
  logic                 ifid_valid_q, ifid_valid_d;

  logic [ADDR_W-1:0]    pc_next;

  assign pc_next     = pc_q + ADDR_W'(PC_STEP);
  assign Imem_Req    = !rst && (state_q != S_BUFFERED);
  assign Imem_Addr   = pc_q;
  assign IF_ID_PC    = ifid_pc_q;
  assign IF_ID_Instr = ifid_instr_q;
  assign IF_ID_Valid = ifid_valid_q;
  assign dbg_state_o = state_q;

  // Next-state, PC and IF/ID update logic; every path defaults to "hold".
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    target_d     = target_q;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;

    unique case (state_q)
      S_FETCH: begin
        if (Branch_Taken && !Freeze) begin
          ifid_pc_d    = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          if (Imem_Ready) begin
            // Response for the wrong path completes now: drop it and jump.
            pc_d = Branch_Addr;
          end else begin
            target_d = Branch_Addr;
            state_d  = S_KILL;
          end
        end else if (Imem_Ready && !Freeze) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = Imem_Data;
          ifid_valid_d = 1'b1;
          pc_d         = pc_next;
        end else if (Imem_Ready) begin
          // Decode is stalled: park the word so it is neither lost nor refetched.
          buf_pc_d    = pc_q;
          buf_instr_d = Imem_Data;
          pc_d        = pc_next;
          state_d     = S_BUFFERED;
        end else if (!Freeze) begin
          ifid_pc_d    = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
        end
      end

      S_BUFFERED: begin
        if (Branch_Taken && !Freeze) begin
          ifid_pc_d    = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          pc_d         = Branch_Addr;
          buf_pc_d     = '0;
          buf_instr_d  = '0;
          state_d      = S_FETCH;
        end else if (!Freeze) begin
          ifid_pc_d    = buf_pc_q;
          ifid_instr_d = buf_instr_q;
          ifid_valid_d = 1'b1;
          state_d      = S_FETCH;
        end
      end

      S_KILL: begin
        // Redirect already captured; further Branch_Taken pulses are ignored.
        if (!Freeze) begin
          ifid_pc_d    = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
        end
        if (Imem_Ready) begin
          pc_d    = target_q;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      target_q     <= '0;
      buf_pc_q     <= '0;
      buf_instr_q  <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed steps, a memory model returning addr+0x100,
// and a scoreboard of {PC, instruction} entries expected in IF/ID.
module tb_if_stage;

  localparam logic [1:0] ST_FETCH    = 2'd0;
  localparam logic [1:0] ST_BUFFERED = 2'd1;
  localparam logic [1:0] ST_KILL     = 2'd2;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        Freeze;
  logic        Branch_Taken;
  logic [31:0] Branch_Addr;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ready;
  logic [31:0] Imem_Data;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;
  logic [1:0]  dbg_state;

  // Second instance with a reset PC at the top of the address space
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic        w_valid;
  logic [1:0]  w_state;

  // Memory model: word at address A is A+0x100
  assign Imem_Data = Imem_Addr + 32'h100;
  assign w_data    = w_addr + 32'h100;

  if_stage dut (
    .clk(clk), .rst(rst), .Freeze(Freeze),
    .Branch_Taken(Branch_Taken), .Branch_Addr(Branch_Addr),
    .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Ready(Imem_Ready), .Imem_Data(Imem_Data),
    .IF_ID_PC(IF_ID_PC), .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_Valid(IF_ID_Valid), .dbg_state_o(dbg_state)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .Freeze(Freeze),
    .Branch_Taken(Branch_Taken), .Branch_Addr(Branch_Addr),
    .Imem_Req(w_req), .Imem_Addr(w_addr),
    .Imem_Ready(Imem_Ready), .Imem_Data(w_data),
    .IF_ID_PC(w_pc), .IF_ID_Instr(w_instr),
    .IF_ID_Valid(w_valid), .dbg_state_o(w_state)
  );

  // Scoreboard
  logic [63:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [63:0] ent(input logic [31:0] a);
    return {a, a + 32'h100};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Compare IF/ID after an edge that was allowed to update it
  task automatic mon();
    logic [63:0] e;
    if (IF_ID_Valid === 1'b1) begin
      chk("sb_pending", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ifid_entry", {IF_ID_PC, IF_ID_Instr}, e);
      end
    end else begin
      chk("bubble", {IF_ID_PC, IF_ID_Instr}, 64'd0);
    end
  endtask

  // Driver: advance one clock, inputs already applied; observe at negedge
  task automatic cycle();
    logic f, r;
    f = Freeze;
    r = rst;
    @(posedge clk);
    @(negedge clk);
    if (!r && !f) mon();
  endtask

  initial begin
    rst = 1'b1; Freeze = 1'b0; Branch_Taken = 1'b0; Branch_Addr = '0; Imem_Ready = 1'b0;
    cycle(); cycle();

    // Reset state
    chk("rst_valid", 64'(IF_ID_Valid), 64'd0);
    chk("rst_ifid", {IF_ID_PC, IF_ID_Instr}, 64'd0);
    chk("rst_req", 64'(Imem_Req), 64'd0);
    chk("rst_addr", 64'(Imem_Addr), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_FETCH));
    chk("wrap_rst_addr", 64'(w_addr), 64'hFFFF_FFFC);

    // Streaming with Ready tied high
    rst = 1'b0; Imem_Ready = 1'b1;
    #1;
    chk("run_req", 64'(Imem_Req), 64'd1);
    chk("run_addr0", 64'(Imem_Addr), 64'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(32'(i * 4)));
    cycle();
    chk("wrap_addr", 64'(w_addr), 64'd0);
    chk("wrap_ifid", {w_pc, w_instr}, {32'hFFFF_FFFC, 32'h0000_00FC});
    chk("wrap_valid", {62'd0, w_valid, w_req}, 64'd3);
    chk("wrap_state", 64'(w_state), 64'(ST_FETCH));
    cycle(); cycle(); cycle();
    Imem_Ready = 1'b0;

    // Wait states: two Ready-low cycles on the first request
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("ws_addr_hold", 64'(Imem_Addr), 64'd0);
      cycle();
    end
    Imem_Ready = 1'b1;
    exp_q.push_back(ent(32'h0));
    #1 chk("ws_addr_last", 64'(Imem_Addr), 64'd0);
    cycle();
    chk("ws_addr_adv", 64'(Imem_Addr), 64'd4);

    // Freeze while a fetch completes
    exp_q.push_back(ent(32'h4));
    cycle();
    Freeze = 1'b1;
    exp_q.push_back(ent(32'h8));
    cycle();
    chk("frz_state", 64'(dbg_state), 64'(ST_BUFFERED));
    chk("frz_req", 64'(Imem_Req), 64'd0);
    chk("frz_ifid_hold", {IF_ID_PC, 31'd0, IF_ID_Valid}, {32'h4, 32'h1});
    cycle(); cycle();
    chk("frz_ifid_hold3", 64'(IF_ID_PC), 64'h4);
    chk("frz_state3", 64'(dbg_state), 64'(ST_BUFFERED));
    Freeze = 1'b0;
    exp_q.push_back(ent(32'hC));
    cycle();
    chk("unfrz_state", 64'(dbg_state), 64'(ST_FETCH));
    cycle();
    Imem_Ready = 1'b0;
    #1 chk("unfrz_addr", 64'(Imem_Addr), 64'h10);

    // Branch while the fetch of 0x10 is waiting
    Branch_Taken = 1'b1; Branch_Addr = 32'h40;
    cycle();
    Branch_Taken = 1'b0;
    chk("kill_state", 64'(dbg_state), 64'(ST_KILL));
    chk("kill_req_addr", {31'd0, Imem_Req, Imem_Addr}, {32'h1, 32'h10});
    cycle();
    chk("kill_addr_hold", 64'(Imem_Addr), 64'h10);
    Imem_Ready = 1'b1; Branch_Taken = 1'b1; Branch_Addr = 32'h80;
    cycle();
    Branch_Taken = 1'b0;
    chk("kill_done_state", 64'(dbg_state), 64'(ST_FETCH));
    chk("kill_target", 64'(Imem_Addr), 64'h40);
    exp_q.push_back(ent(32'h40));
    cycle();
    Imem_Ready = 1'b0;

    // Branch with Freeze high is ignored; branch from BUFFERED flushes
    Freeze = 1'b1; Branch_Taken = 1'b1; Branch_Addr = 32'h200;
    cycle();
    chk("bfrz_addr", 64'(Imem_Addr), 64'h44);
    chk("bfrz_state", 64'(dbg_state), 64'(ST_FETCH));
    Branch_Taken = 1'b0; Imem_Ready = 1'b1;
    cycle();
    chk("bbuf_state", 64'(dbg_state), 64'(ST_BUFFERED));
    Imem_Ready = 1'b0; Branch_Taken = 1'b1;
    cycle();
    chk("bbuf_hold_state", 64'(dbg_state), 64'(ST_BUFFERED));
    chk("bbuf_hold_addr", 64'(Imem_Addr), 64'h48);
    Freeze = 1'b0; Branch_Addr = 32'h300;
    cycle();
    Branch_Taken = 1'b0;
    chk("bflush_state", 64'(dbg_state), 64'(ST_FETCH));
    chk("bflush_addr", 64'(Imem_Addr), 64'h300);
    Imem_Ready = 1'b1;
    exp_q.push_back(ent(32'h300));
    cycle();

    // Zero-wait branch: response discarded, target fetched next cycle
    Branch_Taken = 1'b1; Branch_Addr = 32'h20;
    cycle();
    Branch_Taken = 1'b0;
    chk("bzw_addr", 64'(Imem_Addr), 64'h20);
    chk("bzw_state", 64'(dbg_state), 64'(ST_FETCH));
    exp_q.push_back(ent(32'h20));
    cycle();
    Imem_Ready = 1'b0;

    // Reset while in KILL
    Branch_Taken = 1'b1; Branch_Addr = 32'h500;
    cycle();
    Branch_Taken = 1'b0;
    chk("rk_state", 64'(dbg_state), 64'(ST_KILL));
    rst = 1'b1;
    cycle();
    #1;
    chk("rk_req", 64'(Imem_Req), 64'd0);
    chk("rk_valid", 64'(IF_ID_Valid), 64'd0);
    chk("rk_addr", 64'(Imem_Addr), 64'd0);
    chk("rk_state_after", 64'(dbg_state), 64'(ST_FETCH));
    rst = 1'b0;
    #1 chk("rk_req_release", 64'(Imem_Req), 64'd1);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
